// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Width of a channel index; never zero, even for a single channel.
    function automatic int ch_idx_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: first requester at or above ptr (wrapping), or lowest index in fixed mode.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int IDX_W = ch_idx_w(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    int   start;
    int   ch;
    logic found;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        grant = '0;
        idx   = '0;
        found = 1'b0;
        ch    = 0;
        start = mode ? 0 : int'(ptr);
        for (int k = 0; k < N_CH; k++) begin
            ch = start + k;
            if (ch >= N_CH) ch = ch - N_CH;
            if (!found && req[ch]) begin
                found     = 1'b1;
                grant[ch] = 1'b1;
                idx       = IDX_W'(ch);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with internal arbitration, packet lock and a registered output stage.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int WIDTH    = 8,
    parameter int ARB_MODE = ARB_RR,
    parameter int PKT_LOCK = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           in_valid,
    output logic [N_CH-1:0]           in_ready,
    input  logic [N_CH*WIDTH-1:0]     in_data,
    input  logic [N_CH-1:0]           in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic [ch_idx_w(N_CH)-1:0] out_sel
);

    localparam int IDX_W = ch_idx_w(N_CH);

    logic [IDX_W-1:0] ptr;
    logic             lock;
    logic [IDX_W-1:0] lock_ch;

    logic             load;
    logic [N_CH-1:0]  lock_mask;
    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  grant;
    logic [IDX_W-1:0] g_idx;
    logic             xfer;
    logic [WIDTH-1:0] g_data;
    logic             g_last;
    logic [IDX_W-1:0] ptr_next;

    assign load = !out_valid || out_ready;

    // A held packet narrows the request set to the locked channel alone.
    always_comb begin
        lock_mask          = '0;
        lock_mask[lock_ch] = 1'b1;
        req                = lock ? (in_valid & lock_mask) : in_valid;
    end

    rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .mode  (ARB_MODE == ARB_FIXED),
        .grant (grant),
        .idx   (g_idx)
    );

    assign in_ready = {N_CH{rst_n & load}} & grant;
    assign xfer     = |in_ready;
    assign g_data   = in_data[int'(g_idx)*WIDTH +: WIDTH];
    assign g_last   = in_last[g_idx];
    assign ptr_next = (int'(g_idx) == N_CH - 1) ? '0 : g_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            ptr       <= '0;
            lock      <= 1'b0;
            lock_ch   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            if (load) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= g_data;
                    out_last <= g_last;
                    out_sel  <= g_idx;
                end
            end
            if (xfer && PKT_LOCK != 0) begin
                lock    <= !g_last;
                lock_ch <= g_idx;
            end
            if (xfer && ARB_MODE == ARB_RR && (g_last || PKT_LOCK == 0)) begin
                ptr <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench: a round-robin and a fixed-priority instance, each against a behavioural model.
module tb_stream_mux_rr;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   in_valid [2];
    logic [N-1:0]   in_ready [2];
    logic [N*W-1:0] in_data  [2];
    logic [N-1:0]   in_last  [2];
    logic           out_valid[2];
    logic           out_ready[2];
    logic [W-1:0]   out_data [2];
    logic           out_last [2];
    logic [IW-1:0]  out_sel  [2];

    stream_mux_rr #(.N_CH(N), .WIDTH(W), .ARB_MODE(0), .PKT_LOCK(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .out_sel(out_sel[0])
    );

    stream_mux_rr #(.N_CH(N), .WIDTH(W), .ARB_MODE(1), .PKT_LOCK(1)) u_fx (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .out_sel(out_sel[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: instance 0 is round-robin, instance 1 is fixed priority.
    int m_valid[2], m_data[2], m_last[2], m_sel[2];
    int m_lock[2], m_lch[2], m_ptr[2];
    int acc_ch[2];

    function automatic int model_grant(input int m);
        int start;
        int ch;
        if (m_lock[m] != 0) return in_valid[m][m_lch[m]] ? m_lch[m] : -1;
        start = (m == 1) ? 0 : m_ptr[m];
        for (int k = 0; k < N; k++) begin
            ch = (start + k) % N;
            if (in_valid[m][ch]) return ch;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0; m_data[m] = 0; m_last[m] = 0; m_sel[m] = 0;
            m_lock[m] = 0; m_lch[m] = 0; m_ptr[m] = 0;
        end
    endtask

    // One clock: check in_ready against the model, advance model at the edge, check outputs after it.
    task automatic cycle();
        int  g[2];
        bit  ld[2];
        int  exp_rdy;
        #1;
        for (int m = 0; m < 2; m++) begin
            g[m]    = model_grant(m);
            ld[m]   = (m_valid[m] == 0) || out_ready[m];
            exp_rdy = (rst_n && ld[m] && g[m] >= 0) ? (1 << g[m]) : 0;
            check($sformatf("in_ready[%0d]", m), 32'(in_ready[m]), exp_rdy);
            acc_ch[m] = (exp_rdy != 0) ? g[m] : -1;
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (ld[m]) begin
                    if (g[m] >= 0) begin
                        m_valid[m] = 1;
                        m_data[m]  = int'(in_data[m][g[m]*W +: W]);
                        m_last[m]  = int'(in_last[m][g[m]]);
                        m_sel[m]   = g[m];
                        m_lock[m]  = (m_last[m] == 0) ? 1 : 0;
                        m_lch[m]   = g[m];
                        if (m == 0 && m_last[m] != 0) m_ptr[m] = (g[m] + 1) % N;
                    end else begin
                        m_valid[m] = 0;
                    end
                end
            end
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("out_valid[%0d]", m), 32'(out_valid[m]), m_valid[m]);
            check($sformatf("out_data[%0d]", m),  32'(out_data[m]),  m_data[m]);
            check($sformatf("out_last[%0d]", m),  32'(out_last[m]),  m_last[m]);
            check($sformatf("out_sel[%0d]", m),   32'(out_sel[m]),   m_sel[m]);
        end
    endtask

    task automatic set_ch(input int m, input int ch, input bit v, input int d, input bit l);
        in_valid[m][ch]      = v;
        in_data[m][ch*W +: W] = W'(d);
        in_last[m][ch]       = l;
    endtask

    task automatic idle(input int m);
        in_valid[m] = '0;
        in_data[m]  = '0;
        in_last[m]  = '0;
    endtask

    logic [W-1:0] seq_data[5];
    logic [IW-1:0] seq_sel[5];

    initial begin
        model_reset();
        for (int m = 0; m < 2; m++) begin
            acc_ch[m]    = -1;
            out_ready[m] = 1'b1;
            idle(m);
            in_valid[m] = '1;
        end
        rst_n = 1'b0;

        // Reset with every channel requesting.
        repeat (2) cycle();
        check("rst out_valid", 32'(out_valid[0]), 0);
        check("rst in_ready",  32'(in_ready[0]),  0);
        check("rst out_data",  32'(out_data[0]),  0);
        check("rst out_sel",   32'(out_sel[0]),   0);

        // Round-robin fairness, all single-beat packets.
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < N; c++) set_ch(m, c, 1'b1, 8'hA0 + c, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            seq_data[i] = out_data[0];
            seq_sel[i]  = out_sel[0];
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr data %0d", i), 32'(seq_data[i]), 8'hA0 + (i % N));
            check($sformatf("rr sel %0d", i),  32'(seq_sel[i]),  i % N);
        end

        // Fixed priority with ch0 and ch2 always valid.
        in_valid[1] = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fx ready ch2", 32'(in_ready[1][2]), 0);
            cycle();
            check("fx data", 32'(out_data[1]), 8'hA0);
        end

        // Backpressure on the round-robin instance.
        idle(0);
        idle(1);
        set_ch(0, 0, 1'b1, 8'h55, 1'b1);
        cycle();
        check("bp first", 32'(out_data[0]), 8'h55);
        set_ch(0, 0, 1'b1, 8'h56, 1'b1);
        out_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp ready", 32'(in_ready[0]), 0);
            cycle();
            check("bp hold", 32'(out_data[0]), 8'h55);
        end
        out_ready[0] = 1'b1;
        cycle();
        check("bp release", 32'(out_data[0]), 8'h56);

        // Packet lock: ch1 three-beat packet, ch0/ch2 join from beat 2.
        idle(0);
        set_ch(0, 1, 1'b1, 8'h10, 1'b0);
        cycle();
        check("lk b0", 32'(out_data[0]), 8'h10);
        set_ch(0, 1, 1'b1, 8'h11, 1'b0);
        set_ch(0, 0, 1'b1, 8'hC0, 1'b1);
        set_ch(0, 2, 1'b1, 8'hC2, 1'b1);
        cycle();
        check("lk b1", 32'(out_data[0]), 8'h11);
        check("lk b1 sel", 32'(out_sel[0]), 1);
        check("lk b1 last", 32'(out_last[0]), 0);
        set_ch(0, 1, 1'b1, 8'h12, 1'b1);
        cycle();
        check("lk b2", 32'(out_data[0]), 8'h12);
        check("lk b2 last", 32'(out_last[0]), 1);
        set_ch(0, 1, 1'b0, 8'h00, 1'b0);
        cycle();
        check("lk then ch2", 32'(out_data[0]), 8'hC2);
        set_ch(0, 2, 1'b0, 8'h00, 1'b0);
        cycle();
        check("lk then ch0", 32'(out_data[0]), 8'hC0);

        // Reset mid-packet clears lock and pointer.
        idle(0);
        set_ch(0, 1, 1'b1, 8'h10, 1'b0);
        cycle();
        rst_n = 1'b0;
        cycle();
        check("mid rst valid", 32'(out_valid[0]), 0);
        rst_n = 1'b1;
        set_ch(0, 0, 1'b1, 8'h20, 1'b1);
        set_ch(0, 1, 1'b1, 8'h21, 1'b0);
        cycle();
        check("mid rst winner", 32'(out_sel[0]), 0);
        check("mid rst data", 32'(out_data[0]), 8'h20);

        // Randomised traffic: producers hold each beat until its handshake.
        for (int i = 0; i < 3000; i++) begin
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < N; c++) begin
                    if (acc_ch[m] == c)
                        set_ch(m, c, ($urandom % 4) != 0, $urandom % 256, ($urandom % 3) == 0);
                    else if (!in_valid[m][c])
                        set_ch(m, c, ($urandom % 3) == 0, $urandom % 256, ($urandom % 3) == 0);
                end
                out_ready[m] = ($urandom % 10) < 7;
            end
            rst_n = ($urandom % 250) != 0;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N:1 stream multiplexer with valid/ready handshakes and a registered output.
- Arbitration is internal (round-robin or fixed priority) instead of an external sel input.
- Packet lock: once a packet starts on a channel, that channel keeps the output until its last beat.
- Sits between multiple producer streams and one shared consumer; the general successor to the combinational 4:1 mux.

Parameters:
- N_CH, 4, number of input channels (>=2).
- WIDTH, 8, data width per channel.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- PKT_LOCK, 1, 1 = hold grant until in_last beat; 0 = arbitrate every beat.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready, combinational.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  N_CH  per-channel end-of-packet flag.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts.
- out_data  output  WIDTH  registered data.
- out_last  output  1  registered last flag.
- out_sel  output  $clog2(N_CH)  source channel of the current out beat.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - rr pointer=0, lock=0.
  - in_ready forced to all-0 while rst_n=0.
- load = !out_valid || out_ready. Full throughput: 1 beat/cycle. Latency input→output: 1 cycle.
- Grant (combinational, one-hot or zero):
  - If lock=1, grant=locked channel if its in_valid=1, else none.
  - Otherwise, in RR mode: first valid channel searching from pointer upward, wrapping N_CH-1→0.
  - Otherwise, in fixed mode: lowest-index valid channel.
- in_ready[i] = load && grant[i]. Transfer on channel i = in_valid[i] && in_ready[i].
- On transfer from channel g:
  - out_valid<=1; out_data<=in_data[g]; out_last<=in_last[g]; out_sel<=g.
- If load=1 and there is no transfer: out_valid<=0, out_data/out_last/out_sel hold.
- If load=0: all output registers hold; no input is accepted.
- Lock (PKT_LOCK=1):
  - Transfer with in_last=0 sets lock=1 and locked channel=g.
  - Transfer with in_last=1 clears lock.
  - A single-beat packet never locks.
  - While locked, the locked channel dropping in_valid stalls the output (bubble); other channels stay blocked.
- Pointer (RR mode only):
  - Updates to (g+1) mod N_CH on a transfer with in_last=1, or on any transfer when PKT_LOCK=0.
  - Held otherwise. Fixed mode never changes the pointer.
- Wrap: pointer and search indices wrap modulo N_CH; N_CH need not be a power of two.
- Simultaneous events:
  - out_ready with a new transfer in the same cycle → output replaced, no bubble.
  - Several valids → exactly one grant.
- Reset mid-packet: lock cleared, pointer=0, in-flight out beat discarded (out_valid=0 next cycle).
- Producers must not drop in_valid or change in_data before their handshake; this is not checked.

Decomposition:
- Package stream_mux_pkg: ARB_RR=0 / ARB_FIXED=1 constants; channel-index width helper.
- Sub-module rr_arbiter:
  - Inputs: req[N_CH], ptr, mode.
  - Outputs: one-hot grant and its encoded index.
  - Purely combinational, reusable elsewhere.
- Top level holds the output register, lock register and pointer.

Test Plan (N_CH=4, WIDTH=8, PKT_LOCK=1 unless stated):
1. Reset: rst_n=0 for 2 cycles, in_valid=1111 → out_valid=0, in_ready=0000, out_data=0x00, out_sel=0.
2. RR fairness:
   - Stimulus: all valid, out_ready=1, in_last=1111, data ch0..3=0xA0..0xA3.
   - Required: out_data sequence A0,A1,A2,A3,A0 on consecutive cycles; out_sel 0,1,2,3,0.
3. Fixed priority: ARB_MODE=1, ch0 and ch2 valid continuously → only 0xA0 forwarded every cycle; in_ready[2]=0 throughout.
4. Backpressure:
   - Stimulus: out_valid=1, out_data=0x55, out_ready=0 for 3 cycles, then 1.
   - Required: out_data holds 0x55 and in_ready=0000 during the stall; the next beat appears the cycle after release.
5. Packet lock:
   - Stimulus: ch1 valid alone sends 3-beat packet 0x10,0x11,0x12 (last 0,0,1); ch0 and ch2 assert valid from beat 2.
   - Required: 0x10,0x11,0x12 contiguous with out_sel=1; then ch2 (pointer=2), then ch0; out_last=1 only on 0x12.
6. Reset mid-packet: rst_n=0 one cycle after ch1 beat 0x10 (lock set) → next cycle out_valid=0; after release with ch0 and ch1 valid, ch0 wins (pointer=0, lock cleared).
